// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner for HH:MM:SS with per-frame snapshot and alarm blink.
// Optional: define LEADING_ZERO_BLANK_EN to blank a leading zero on the hours tens digit.
module clock_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hour_in1,
  input  logic [3:0] hour_in0,
  input  logic [3:0] min_in1,
  input  logic [3:0] min_in0,
  input  logic [3:0] sec_in1,
  input  logic [3:0] sec_in0,
  input  logic       alarm_in,
  input  logic       display_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc, presc_next;
  logic [2:0]        idx, idx_next;
  logic [5:0][3:0]   snap, snap_next;
  logic [BW-1:0]     blink_cnt, blink_cnt_next;
  logic              blink_phase, blink_phase_next;
  logic              slot_tick, frame_start;
  logic [3:0]        digit;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [5:0]        an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    case (value)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // Outputs are registered from next-state values so they line up with the new index.
  always_comb begin
    slot_tick        = (presc == PRESC_LAST);
    frame_start      = slot_tick && (idx == 3'd5);
    presc_next       = slot_tick ? '0 : presc + PW'(1);
    idx_next         = idx;
    snap_next        = snap;
    blink_cnt_next   = blink_cnt;
    blink_phase_next = blink_phase;

    if (slot_tick)
      idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    if (frame_start)
      snap_next = {{2'b00, hour_in1}, hour_in0, min_in1, min_in0, sec_in1, sec_in0};

    if (!alarm_in) begin
      blink_cnt_next   = '0;
      blink_phase_next = 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next = blink_cnt + BW'(1);
      end
    end

    digit    = snap_next[idx_next];
    an_next  = ~(6'b000001 << idx_next);
    seg_next = seg_decode(digit);
    dp_next  = !((idx_next == 3'd2) || (idx_next == 3'd4));

`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_next == 3'd5) && (digit == 4'd0)) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end
`endif

    if (!display_en) begin
      an_next  = 6'h3F;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end else if (blink_phase_next) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      snap        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an_n        <= 6'h3F;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      presc       <= presc_next;
      idx         <= idx_next;
      snap        <= snap_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
      an_n        <= an_next;
      seg_n       <= seg_next;
      dp_n        <= dp_next;
      frame_tick  <= frame_start;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan against a cycle-count based reference model.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, min_in1, min_in0, sec_in1, sec_in0;
  logic       alarm_in, display_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_tick;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: cycles since reset release, snapshot, blink.
  int         t;
  logic [3:0] m_snap [6];
  int         m_cnt;
  bit         m_phase;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [5:0] exp_an;
  logic       exp_ft;

  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .hour_in1(hour_in1), .hour_in0(hour_in0), .min_in1(min_in1), .min_in0(min_in0),
    .sec_in1(sec_in1), .sec_in0(sec_in0), .alarm_in(alarm_in), .display_en(display_en),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                               input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    hour_in1 = h1; hour_in0 = h0; min_in1 = m1; min_in0 = m0; sec_in1 = s1; sec_in0 = s0;
  endtask

  function automatic logic [3:0] randDigit();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic modelReset();
    t = 0; m_cnt = 0; m_phase = 0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare at the falling edge.
  task automatic stepCycle();
    bit fs;
    bit en;
    int idx;
    logic [3:0] d;
    @(posedge clk);
    en = display_en;
    fs = (t % FRAME) == FRAME - 1;
    if (fs) begin
      m_snap[0] = sec_in0; m_snap[1] = sec_in1; m_snap[2] = min_in0;
      m_snap[3] = min_in1; m_snap[4] = hour_in0; m_snap[5] = {2'b00, hour_in1};
    end
    if (!alarm_in) begin
      m_cnt = 0; m_phase = 0;
    end else if (fs) begin
      m_cnt++;
      if (m_cnt == BF) begin m_cnt = 0; m_phase = !m_phase; end
    end
    t++;
    idx = (t / SD) % 6;
    d = m_snap[idx];
    exp_ft = fs;
    exp_an = en ? ~(6'd1 << idx) : 6'h3F;
    exp_seg = (d < 10) ? seg_lut[d] : 7'h3F;
    exp_dp = !(idx == 2 || idx == 4);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 5 && d == 0) begin exp_seg = 7'h7F; exp_dp = 1'b1; end
`endif
    if (!en || m_phase) begin exp_seg = 7'h7F; exp_dp = 1'b1; end
    @(negedge clk);
    checkOutput("an_n", 32'(an_n), 32'(exp_an));
    checkOutput("seg_n", 32'(seg_n), 32'(exp_seg));
    checkOutput("dp_n", 32'(dp_n), 32'(exp_dp));
    checkOutput("frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic checkBlank(input string tag);
    checkOutput({tag, "_an"}, 32'(an_n), 32'h3F);
    checkOutput({tag, "_seg"}, 32'(seg_n), 32'h7F);
    checkOutput({tag, "_dp"}, 32'(dp_n), 32'h1);
    checkOutput({tag, "_ft"}, 32'(frame_tick), 32'h0);
  endtask

  logic [5:0] dir_an [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [6:0] dir_seg [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic       dir_dp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    alarm_in = 1'b0;
    display_en = 1'b1;
    applyStimulus(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    #1 checkBlank("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();

    // Initial frames show the cleared snapshot regardless of the inputs.
    applyStimulus(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    repeat (FRAME + 7) stepCycle();

    // Asynchronous reset in the middle of a slot.
    #2 reset = 1'b1;
    #1 checkBlank("midreset");
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    repeat (2 * FRAME) stepCycle();

    // Directed 12:34:56 frame, with inputs switching to 23:59:59 halfway through.
    begin
      int waited = 0;
      while (frame_tick !== 1'b1 && waited < 2 * FRAME) begin
        stepCycle();
        waited++;
      end
      if (frame_tick !== 1'b1) checkOutput("frame_tick_timeout", 32'(frame_tick), 32'h1);
      for (int k = 0; k < 6; k++) begin
        checkOutput("dir_an", 32'(an_n), 32'(dir_an[k]));
        checkOutput("dir_seg", 32'(seg_n), 32'(dir_seg[k]));
        checkOutput("dir_dp", 32'(dp_n), 32'(dir_dp[k]));
        if (k == 2) applyStimulus(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        repeat (SD) stepCycle();
      end
    end
    repeat (FRAME) stepCycle();

    // Randomized run: digit changes, alarm blinking, display enable gaps.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0)
        applyStimulus(2'($urandom_range(0, 3)), randDigit(), randDigit(),
                      randDigit(), randDigit(), randDigit());
      if ($urandom_range(0, 199) == 0) alarm_in = ~alarm_in;
      if (display_en ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0))
        display_en = ~display_en;
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
